// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back arbiter slice.
// Imported by the interface, the scoreboard and the top.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Core-side bundle of the write-back arbiter: EXU/LSU handshakes,
// load issue, hazard query and the registered register-file port.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic                  exu_valid;
    logic                  exu_ready;
    logic [REG_ADDR_W-1:0] exu_rd;
    logic [XLEN-1:0]       exu_data;

    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic                  ld_issue_ok;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;

    logic [REG_ADDR_W-1:0] q_rs1;
    logic [REG_ADDR_W-1:0] q_rs2;
    logic                  q_hazard;

    logic                  rf_wen;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  err;

    modport master (
        output exu_valid, exu_rd, exu_data,
        output ld_issue, ld_issue_rd,
        output lsu_valid, lsu_rd, lsu_data,
        output q_rs1, q_rs2,
        input  exu_ready, ld_issue_ok, lsu_ready, q_hazard,
        input  rf_wen, rf_waddr, rf_wdata, err
    );

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  ld_issue, ld_issue_rd,
        input  lsu_valid, lsu_rd, lsu_data,
        input  q_rs1, q_rs2,
        output exu_ready, ld_issue_ok, lsu_ready, q_hazard,
        output rf_wen, rf_waddr, rf_wdata, err
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Outstanding-load tracking: load counter, per-register busy bits,
// issue gating, source hazard query and the sticky protocol error.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int MAX_LD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_issue_i,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd_i,
    input  logic                  lsu_xfer_i,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic                  exu_xfer_i,
    input  logic [REG_ADDR_W-1:0] exu_rd_i,
    input  logic [REG_ADDR_W-1:0] q_rs1_i,
    input  logic [REG_ADDR_W-1:0] q_rs2_i,
    output logic                  ld_issue_ok_o,
    output logic                  q_hazard_o,
    output logic                  err_o
);

    localparam logic [1:0] MAX = 2'(MAX_LD);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] busy_q, busy_d;
    logic        err_q, err_d;
    logic        issue_go;
    logic        spurious;
    logic        ld_done;

    assign ld_issue_ok_o = (cnt_q < MAX) && !busy_q[ld_issue_rd_i];
    assign issue_go      = ld_issue_i && ld_issue_ok_o;
    assign spurious      = lsu_xfer_i && (cnt_q == 2'd0);
    assign ld_done       = lsu_xfer_i && !spurious;
    assign q_hazard_o    = busy_q[q_rs1_i] | busy_q[q_rs2_i];
    assign err_o         = err_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({issue_go, ld_done})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // clear before set so a retiring rd and a new rd both land
        busy_d = busy_q;
        if (lsu_xfer_i) busy_d[lsu_rd_i] = 1'b0;
        if (issue_go)   busy_d[ld_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
        err_d = err_q | spurious | (exu_xfer_i && busy_q[exu_rd_i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one EXU/LSU grant per cycle into a registered RF port.
// WB_ARB_RR_EN selects round-robin contention; default is fixed LSU priority.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int MAX_LD = 2
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);

    logic                  exu_rdy, lsu_rdy;
    logic                  rf_wen_q, rf_wen_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

`ifdef WB_ARB_RR_EN
    wb_src_e last_q;

    always_comb begin
        exu_rdy = 1'b0;
        lsu_rdy = 1'b0;
        unique case (1'b1)
            bus.exu_valid && bus.lsu_valid: begin
                exu_rdy = (last_q == SRC_LSU);
                lsu_rdy = (last_q == SRC_EXU);
            end
            bus.lsu_valid && !bus.exu_valid: lsu_rdy = 1'b1;
            bus.exu_valid && !bus.lsu_valid: exu_rdy = 1'b1;
            default: ;
        endcase
    end

    // Reset as if LSU won last so the first contention goes to EXU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= SRC_LSU;
        else if (bus.exu_valid && bus.lsu_valid)
            last_q <= exu_rdy ? SRC_EXU : SRC_LSU;
    end
`else
    assign lsu_rdy = bus.lsu_valid;
    assign exu_rdy = bus.exu_valid && !bus.lsu_valid;
`endif

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (lsu_rdy && bus.lsu_rd != '0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = bus.lsu_rd;
            rf_wdata_d = bus.lsu_data;
        end else if (exu_rdy && bus.exu_rd != '0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = bus.exu_rd;
            rf_wdata_d = bus.exu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    wb_scoreboard #(.MAX_LD(MAX_LD)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_issue_i    (bus.ld_issue),
        .ld_issue_rd_i (bus.ld_issue_rd),
        .lsu_xfer_i    (lsu_rdy),
        .lsu_rd_i      (bus.lsu_rd),
        .exu_xfer_i    (exu_rdy),
        .exu_rd_i      (bus.exu_rd),
        .q_rs1_i       (bus.q_rs1),
        .q_rs2_i       (bus.q_rs2),
        .ld_issue_ok_o (bus.ld_issue_ok),
        .q_hazard_o    (bus.q_hazard),
        .err_o         (bus.err)
    );

    assign bus.exu_ready = exu_rdy;
    assign bus.lsu_ready = lsu_rdy;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus reset/round-robin
// sequences; WB_ARB_RR_EN swaps the fixed-priority table for an RR run.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.MAX_LD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        li;
        logic [4:0]  lird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        x_erdy;
        logic        x_lrdy;
        logic        x_ok;
        logic        x_hz;
        logic        x_wen;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
        logic        x_err;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(
        logic ev, logic [4:0] erd, logic [31:0] ed,
        logic lv, logic [4:0] lrd, logic [31:0] ld,
        logic li, logic [4:0] lird,
        logic [4:0] r1, logic [4:0] r2,
        logic erdy, logic lrdy, logic ok, logic hz,
        logic wen, logic [4:0] wa, logic [31:0] wd, logic e);
        vec_t v;
        v.ev = ev; v.erd = erd; v.ed = ed;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.li = li; v.lird = lird; v.r1 = r1; v.r2 = r2;
        v.x_erdy = erdy; v.x_lrdy = lrdy; v.x_ok = ok; v.x_hz = hz;
        v.x_wen = wen; v.x_wa = wa; v.x_wd = wd; v.x_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.ld_issue = 1'b0; bus.ld_issue_rd = '0;
        bus.q_rs1 = '0; bus.q_rs2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = mk(1,5,32'h12345678, 0,0,0, 0,0,  0,0,  1,0,1,0, 1,5,32'h12345678,0);
        tv[1]  = mk(0,0,0,            0,0,0, 1,4,  0,0,  0,0,1,0, 0,5,32'h12345678,0);
        tv[2]  = mk(1,3,32'h33,       1,4,32'h44, 0,0, 4,0, 0,1,1,1, 1,4,32'h44,0);
        tv[3]  = mk(1,3,32'h33,       0,0,0, 0,0,  4,0,  1,0,1,0, 1,3,32'h33,0);
        tv[4]  = mk(0,0,0,            0,0,0, 1,7,  7,0,  0,0,1,0, 0,3,32'h33,0);
        tv[5]  = mk(0,0,0,            0,0,0, 1,8,  7,0,  0,0,1,1, 0,3,32'h33,0);
        tv[6]  = mk(0,0,0,            0,0,0, 1,10, 0,7,  0,0,0,1, 0,3,32'h33,0);
        tv[7]  = mk(0,0,0,            1,7,32'h77, 1,10, 7,0, 0,1,0,1, 1,7,32'h77,0);
        tv[8]  = mk(0,0,0,            0,0,0, 1,10, 7,0,  0,0,1,0, 0,7,32'h77,0);
        tv[9]  = mk(0,0,0,            1,8,32'h88, 1,9, 0,0, 0,1,0,0, 1,8,32'h88,0);
        tv[10] = mk(0,0,0,            1,10,32'haa, 1,9, 10,0, 0,1,1,1, 1,10,32'haa,0);
        tv[11] = mk(1,0,32'hdeadbeef, 0,0,0, 1,9, 10,9, 1,0,0,1, 0,10,32'haa,0);
        tv[12] = mk(1,9,32'h99,       0,0,0, 0,0, 10,0, 1,0,1,0, 1,9,32'h99,1);
        tv[13] = mk(0,0,0,            1,9,32'h90, 0,0, 0,0, 0,1,1,0, 1,9,32'h90,1);

        idle();
        step();
        step();
        chk("rst_wen",   bus.rf_wen, 0);
        chk("rst_waddr", bus.rf_waddr, 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        chk("rst_err",   bus.err, 0);
        chk("rst_hz",    bus.q_hazard, 0);
        chk("rst_ok",    bus.ld_issue_ok, 1);
        rst_n = 1'b1;

`ifdef WB_ARB_RR_EN
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd1; bus.exu_data = 32'h1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rr%0d_exu", i), bus.exu_ready, (i % 2 == 0));
            chk($sformatf("rr%0d_lsu", i), bus.lsu_ready, (i % 2 == 1));
            step();
        end
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
`else
        for (int i = 0; i < 14; i++) begin
            bus.exu_valid = tv[i].ev; bus.exu_rd = tv[i].erd;
            bus.exu_data = tv[i].ed;
            bus.lsu_valid = tv[i].lv; bus.lsu_rd = tv[i].lrd;
            bus.lsu_data = tv[i].ld;
            bus.ld_issue = tv[i].li; bus.ld_issue_rd = tv[i].lird;
            bus.q_rs1 = tv[i].r1; bus.q_rs2 = tv[i].r2;
            #3;
            chk($sformatf("v%0d_exu_ready", i), bus.exu_ready, tv[i].x_erdy);
            chk($sformatf("v%0d_lsu_ready", i), bus.lsu_ready, tv[i].x_lrdy);
            chk($sformatf("v%0d_ld_ok", i), bus.ld_issue_ok, tv[i].x_ok);
            chk($sformatf("v%0d_hazard", i), bus.q_hazard, tv[i].x_hz);
            step();
            chk($sformatf("v%0d_rf_wen", i), bus.rf_wen, tv[i].x_wen);
            chk($sformatf("v%0d_rf_waddr", i), bus.rf_waddr, tv[i].x_wa);
            chk($sformatf("v%0d_rf_wdata", i), bus.rf_wdata, tv[i].x_wd);
            chk($sformatf("v%0d_err", i), bus.err, tv[i].x_err);
        end
`endif

        // reset while a load is in flight
        idle();
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd12;
        step();
        bus.ld_issue = 1'b0; bus.q_rs1 = 5'd12;
        #1;
        chk("ml_hz_before", bus.q_hazard, 1);
        rst_n = 1'b0;
        #1;
        chk("ml_rst_err", bus.err, 0);
        chk("ml_rst_hz",  bus.q_hazard, 0);
        chk("ml_rst_wen", bus.rf_wen, 0);
        chk("ml_rst_ok",  bus.ld_issue_ok, 1);
        step();
        rst_n = 1'b1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hc;
        #1;
        chk("sp_lsu_ready", bus.lsu_ready, 1);
        step();
        bus.lsu_valid = 1'b0;
        chk("sp_err",   bus.err, 1);
        chk("sp_wen",   bus.rf_wen, 1);
        chk("sp_waddr", bus.rf_waddr, 12);
        step();
        chk("sp_err_sticky", bus.err, 1);
        chk("sp_cnt_zero_ok", bus.ld_issue_ok, 1);
        chk("sp_wen_idle", bus.rf_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter MAX_LD, default 2, max outstanding loads (1..3).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 exu_valid  input  1  EXU result (ALU or PC+4) pending write-back.
REQ-005 exu_ready  output  1  EXU result accepted this cycle.
REQ-006 exu_rd / exu_data  input  5 / 32  EXU destination register / value.
REQ-007 ld_issue  input  1  core requests to issue a load.
REQ-008 ld_issue_rd  input  5  issued load's destination register.
REQ-009 ld_issue_ok  output  1  issue permitted this cycle.
REQ-010 lsu_valid  input  1  load response pending.
REQ-011 lsu_ready  output  1  load response accepted this cycle.
REQ-012 lsu_rd / lsu_data  input  5 / 32  load destination / extended load data.
REQ-013 q_rs1 / q_rs2  input  5 / 5  source registers queried for hazard.
REQ-014 q_hazard  output  1  a queried source awaits an outstanding load.
REQ-015 rf_wen / rf_waddr / rf_wdata  output  1 / 5 / 32  registered register-file write port.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 One write-back grant per cycle; exu_ready and lsu_ready SHALL never both be 1.
REQ-018 Fixed priority: LSU over EXU when both valid; a lone valid requester is always granted.
REQ-019 ready SHALL be combinational from valids and arbiter state; transfer = valid && ready.
REQ-020 Latency 1: a cycle-N transfer drives rf_wen=1, rf_waddr=rd, rf_wdata=data in cycle N+1; no transfer -> rf_wen=0 (waddr/wdata hold).
REQ-021 rd==0 transfer SHALL be consumed with rf_wen=0 in cycle N+1.
REQ-022 Outstanding counter ld_cnt (2 bits): +1 on ld_issue && ld_issue_ok; -1 on LSU transfer; both in one cycle -> unchanged.
REQ-023 ld_issue_ok = (ld_cnt < MAX_LD) && !busy[ld_issue_rd]; same-rd loads never overlap.
REQ-024 Busy vector busy[31:1]: set on permitted issue (rd≠0); cleared on LSU transfer of lsu_rd; x0 never busy.
REQ-025 Same-cycle clear of rd A and set of rd B (A≠B) SHALL both take effect.
REQ-026 q_hazard = busy[q_rs1] | busy[q_rs2], combinational; cleared the cycle after the response transfer.
REQ-027 lsu_valid while ld_cnt==0 -> err set next cycle, response consumed, counter stays 0.
REQ-028 EXU result with exu_rd busy -> err set (WAW violation), write still performed.

Reset
REQ-029 rst_n low SHALL asynchronously clear rf_wen, rf_waddr, rf_wdata, ld_cnt, busy, err, arbiter state; ready outputs follow the cleared state.
REQ-030 Loads outstanding at reset SHALL be forgotten; post-reset responses are errors per REQ-027.

Configuration
REQ-031 WB_ARB_RR_EN defined: round-robin; when both valid, grant the requester not granted at last contention; reset state grants EXU first.
REQ-032 WB_ARB_RR_EN undefined: fixed LSU priority per REQ-018; no arbiter state register.

Structure
REQ-033 Shared package wb_pkg: WB source enum (SRC_EXU, SRC_LSU), REG_ADDR_W=5, XLEN=32.
REQ-034 One sub-module wb_scoreboard: ld_cnt, busy vector, ld_issue_ok, q_hazard, err logic.

Verification
REQ-035 exu_valid=1, rd=5, data=0x12345678 -> exu_ready=1; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678.
REQ-036 Both valid (exu rd=3, lsu rd=4), fixed mode -> lsu granted, rf_waddr=4; EXU held, written next cycle as rd=3.
REQ-037 RR mode, both valid 4 cycles -> grants EXU, LSU, EXU, LSU.
REQ-038 Issue loads rd=7, rd=8 (MAX_LD=2) -> ld_issue_ok=0 on third; q_rs1=7 -> q_hazard=1; response rd=7 -> q_hazard=0 next cycle.
REQ-039 Issue rd=9 twice back-to-back -> second ld_issue_ok=0; exu rd=0 data=0xdeadbeef -> rf_wen=0.
REQ-040 lsu_valid with ld_cnt=0 -> err=1 next cycle, sticky; rst_n low mid-load -> ld_cnt=0, busy=0, err=0 immediately.
